// File: rtl/axis_upsizer.sv
// AXI4-Stream width upsizer: packs RATIO narrow beats (little-endian lanes)
// into one wide word, or passes single beats through in lane 0.
//
// Handshake contract: a beat moves on s_tvalid & s_tready, a word moves on
// m_tvalid & m_tready. s_tready depends only on reset state, m_tvalid and
// m_tready, never on s_tvalid/s_tlast. Once m_tvalid is high, m_tdata,
// m_tkeep and m_tlast hold until the word is taken.
module axis_upsizer #(
  parameter int S_WIDTH = 8,
  parameter int RATIO   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       upsizing,
  input  logic [S_WIDTH-1:0]         s_tdata,
  input  logic                       s_tvalid,
  input  logic                       s_tlast,
  output logic                       s_tready,
  output logic [S_WIDTH*RATIO-1:0]   m_tdata,
  output logic [RATIO-1:0]           m_tkeep,
  output logic                       m_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready
);

  localparam int M_WIDTH = S_WIDTH * RATIO;
  localparam int CW      = $clog2(RATIO) + 1;

  typedef enum logic {EMPTY = 1'b0, PACK = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [M_WIDTH-1:0] acc_q;
  logic [M_WIDTH-1:0] merged;
  logic [RATIO-1:0]   keep_new;
  logic               mode_q;
  logic               run_q;
  logic               eff_mode;
  logic               beat_acc;
  logic               completing;
  logic               load_out;
  logic               acc_en;

  // Ready only once out of reset and the output register is free or draining.
  assign s_tready = run_q & (~m_tvalid | m_tready);
  assign beat_acc = s_tvalid & s_tready;

  // The first beat of a word samples the live mode; later beats use the latched one.
  assign eff_mode   = (state_q == EMPTY) ? upsizing : mode_q;
  assign completing = (cnt_q == CW'(RATIO - 1)) | s_tlast | ~eff_mode;

  // Merge the current beat into its lane and build the keep mask for lanes 0..cnt.
  always_comb begin
    merged   = acc_q;
    keep_new = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_q == CW'(i)) merged[i*S_WIDTH +: S_WIDTH] = s_tdata;
      if (CW'(i) <= cnt_q) keep_new[i] = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // FSM next state: any completing beat returns to EMPTY, otherwise PACK.
  always_comb begin
    state_d = state_q;
    if (beat_acc) state_d = completing ? EMPTY : PACK;
  end

  // FSM outputs: either load the output register or grow the accumulator.
  always_comb begin
    load_out = 1'b0;
    acc_en   = 1'b0;
    if (beat_acc) begin
      load_out = completing;
      acc_en   = ~completing;
    end
  end

  // Accumulator, lane counter and latched mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else if (beat_acc) begin
      if (state_q == EMPTY) mode_q <= upsizing;
      if (acc_en) begin
        acc_q <= merged;
        cnt_q <= cnt_q + 1'b1;
      end else begin
        acc_q <= '0;
        cnt_q <= '0;
      end
    end
  end

  // Output holding register; a new load replaces a word being accepted this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q    <= 1'b0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (load_out) begin
        m_tvalid <= 1'b1;
        m_tdata  <= merged;
        m_tkeep  <= keep_new;
        m_tlast  <= s_tlast;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_upsizer.sv
// Bench for axis_upsizer: directed packets plus a random stream, checked
// against a beat-list reference model and an expected-word queue.
module tb_axis_upsizer;

  localparam int SW = 8;
  localparam int R  = 4;
  localparam int MW = SW * R;
  localparam int EW = 1 + R + MW;  // {last, keep, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          upsizing = 1'b1;
  logic [SW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [MW-1:0] m_tdata;
  logic [R-1:0]  m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready = 1'b1;

  axis_upsizer #(.S_WIDTH(SW), .RATIO(R)) dut (
    .clk(clk), .rst(rst), .upsizing(upsizing),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: beats collected per word, emitted by the packing rules.
  logic [EW-1:0] exp_q[$];
  logic [SW-1:0] beats[R];
  int            nb = 0;        // beats collected in the current word
  logic          wmode = 1'b1;  // mode captured by the word's first beat
  logic          mv = 1'b0;     // model: output word held
  logic          up = 1'b0;     // model: a clock edge has passed since reset release
  logic          acc_now = 1'b0;
  logic [EW-1:0] last_word = '0;

  function automatic logic [EW-1:0] build_word(input int n, input logic last);
    logic [MW-1:0] d;
    logic [R-1:0]  k;
    d = '0;
    k = '0;
    for (int j = 0; j < n; j++) begin
      d = d | (MW'(beats[j]) << (SW * j));
      k[j] = 1'b1;
    end
    return {last, k, d};
  endfunction

  // One cycle: check settled outputs against the model, then advance the model
  // by what the coming rising edge will do.
  task automatic tick();
    logic exp_rdy;
    #1;
    if (!rst) begin
      check("rst_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_tready", 64'(s_tready), 64'(0));
      check("rst_tdata",  64'(m_tdata),  64'(0));
      check("rst_tkeep",  64'(m_tkeep),  64'(0));
      check("rst_tlast",  64'(m_tlast),  64'(0));
      exp_q.delete();
      nb = 0;
      mv = 1'b0;
      up = 1'b0;
      acc_now = 1'b0;
    end else begin
      exp_rdy = up & (~mv | m_tready);
      check("tvalid", 64'(m_tvalid), 64'(mv));
      check("tready", 64'(s_tready), 64'(exp_rdy));
      if (mv && exp_q.size() > 0)
        check("word", 64'({m_tlast, m_tkeep, m_tdata}), 64'(exp_q[0]));
      acc_now = s_tvalid & exp_rdy;
      if (mv && m_tready) begin
        if (exp_q.size() > 0) last_word = exp_q.pop_front();
        mv = 1'b0;
      end
      if (acc_now) begin
        if (nb == 0) wmode = upsizing;
        beats[nb] = s_tdata;
        nb++;
        if (nb == R || s_tlast || !wmode) begin
          exp_q.push_back(build_word(nb, s_tlast));
          nb = 0;
          mv = 1'b1;
        end
      end
      up = 1'b1;
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [SW-1:0] d, input logic last);
    bit done;
    done = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    for (int i = 0; i < 64 && !done; i++) begin
      tick();
      if (acc_now) done = 1;
    end
    if (!done) check("send_timeout", 64'(0), 64'(1));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();  // no edge seen yet since release: s_tready still low

    // Full packed word.
    upsizing = 1'b1;
    m_tready = 1'b1;
    send_beat(8'h11, 0); send_beat(8'h22, 0); send_beat(8'h33, 0); send_beat(8'h44, 1);
    idle(3);
    check("dir_full", 64'(last_word), 64'({1'b1, 4'hF, 32'h44332211}));

    // Partial word and single-beat packet.
    send_beat(8'hAA, 0); send_beat(8'hBB, 0); send_beat(8'hCC, 1);
    idle(2);
    check("dir_partial", 64'(last_word), 64'({1'b1, 4'h7, 32'h00CCBBAA}));
    send_beat(8'h5A, 1);
    idle(2);
    check("dir_single", 64'(last_word), 64'({1'b1, 4'h1, 32'h0000005A}));

    // Pass-through.
    upsizing = 1'b0;
    send_beat(8'h01, 0);
    idle(2);
    check("dir_pass0", 64'(last_word), 64'({1'b0, 4'h1, 32'h00000001}));
    send_beat(8'h02, 1);
    idle(2);
    check("dir_pass1", 64'(last_word), 64'({1'b1, 4'h1, 32'h00000002}));

    // Backpressure after the first word of an 8-beat packet.
    upsizing = 1'b1;
    send_beat(8'h11, 0); send_beat(8'h22, 0); send_beat(8'h33, 0); send_beat(8'h44, 0);
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 8'h55;
    repeat (5) begin
      tick();
      check("bp_no_accept", 64'(acc_now), 64'(0));
    end
    m_tready = 1'b1;
    send_beat(8'h55, 0); send_beat(8'h66, 0); send_beat(8'h77, 0); send_beat(8'h88, 1);
    idle(2);
    check("dir_bp", 64'(last_word), 64'({1'b1, 4'hF, 32'h88776655}));

    // Continuous 16-beat stream.
    for (int i = 0; i < 16; i++) send_beat(8'(i), i == 15);
    idle(2);
    check("dir_stream", 64'(last_word), 64'({1'b1, 4'hF, 32'h0F0E0D0C}));

    // Reset mid-word, then a word with upsizing toggled at cnt==2.
    send_beat(8'hE1, 0); send_beat(8'hE2, 0);
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    send_beat(8'h10, 0); send_beat(8'h11, 0);
    upsizing = 1'b0;
    send_beat(8'h12, 0); send_beat(8'h13, 1);
    idle(2);
    check("dir_rst_mode", 64'(last_word), 64'({1'b1, 4'hF, 32'h13121110}));

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      s_tvalid = 1'($urandom_range(0, 3) != 0);
      s_tdata  = 8'($urandom);
      s_tlast  = 1'($urandom_range(0, 4) == 0);
      upsizing = 1'($urandom_range(0, 5) != 0);
      m_tready = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    m_tready = 1'b1;
    idle(4);
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
- AXI4-Stream width upsizer. Packs RATIO narrow beats of S_WIDTH bits into one wide word of S_WIDTH*RATIO bits.
- Sits directly downstream of the stream-slave stage and consumes the beats that stage accepts.
- Packet boundaries are carried on s_tlast/m_tlast. Partial final words are marked with m_tkeep.
- With upsizing=0 the block runs in pass-through mode: one beat per word, lane 0 only.

Parameters:
- S_WIDTH, 8, width of the input data beat in bits.
- RATIO, 4, beats per output word; must be ≥2. Output width is S_WIDTH*RATIO.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- upsizing  in  1  1 = pack RATIO beats per word; 0 = pass-through (1 beat per word)
- s_tdata  in  S_WIDTH  input beat
- s_tvalid  in  1  input beat valid
- s_tlast  in  1  last beat of packet
- s_tready  out  1  block can accept a beat
- m_tdata  out  S_WIDTH*RATIO  packed output word
- m_tkeep  out  RATIO  per-lane valid mask, bit i covers m_tdata[i*S_WIDTH +: S_WIDTH]
- m_tlast  out  1  word ends packet
- m_tvalid  out  1  output word valid
- m_tready  in  1  downstream accepts word

Behaviour:
- Reset is asynchronous, active-low, on clock clk.
- Reset values: s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0. Accumulator is cleared and the lane counter cnt=0.
- First rising edge after rst deasserts: s_tready may go to 1.
- Reset asserted mid-word or mid-packet: all partial data is discarded. No word is emitted for it.
- Handshakes:
  - Input transfer occurs when s_tvalid & s_tready.
  - Output transfer occurs when m_tvalid & m_tready.
  - s_tready = out of reset & (!m_tvalid | m_tready). It does not depend on s_tvalid or s_tlast.
- Output stability: m_tvalid=1 holds m_tdata, m_tkeep and m_tlast stable until the word is accepted.
- Mode register:
  - upsizing is sampled into mode_q only on an accepted beat with cnt==0.
  - Beats 1..RATIO-1 of a word use mode_q. Changing upsizing mid-word has no effect until the next word.
- Lane order is little-endian. Beat k of a word goes to lane k (bits k*S_WIDTH +: S_WIDTH).
- FSM states:
  - EMPTY (cnt==0, no partial data).
  - PACK (0<cnt<RATIO, partial data held).
  - The output holding register is tracked separately by m_tvalid.
- EMPTY → PACK on an accepted beat that does not complete a word.
- PACK → PACK on an accepted non-completing beat; cnt increments.
- PACK/EMPTY → EMPTY on an accepted completing beat.
- A beat is completing when any of the following holds:
  - cnt==RATIO-1;
  - s_tlast=1;
  - effective mode is pass-through.
- On a completing beat, the merged accumulator plus the current beat is loaded into the output register at the next edge:
  - m_tvalid=1;
  - m_tlast=s_tlast;
  - m_tkeep has bits 0..cnt set.
  - The accumulator clears and cnt=0.
- Latency: m_tvalid rises exactly 1 cycle after the completing beat is accepted.
- Partial word (s_tlast with cnt<RATIO-1): unused lanes carry data 0 and keep 0.
- Pass-through: m_tdata lane 0 = beat, other lanes 0, m_tkeep=1, m_tlast=s_tlast.
- Simultaneous output accept and new load in the same cycle: the new word replaces the old one and m_tvalid stays 1. No bubble, no loss.
- Output accepted with no new load: m_tvalid→0 next cycle.
- Backpressure:
  - While m_tvalid=1 and m_tready=0, s_tready=0. No beats are accepted and the accumulator is frozen.
- Throughput: with m_tready held at 1, one beat is accepted every cycle.
  - Upsizing mode: one word per RATIO cycles.
  - Pass-through mode: one word per cycle.
- No packet-length limit. Packets with zero beats do not exist; tlast always accompanies a beat.
- The counter is log2(RATIO)+1 bits wide and never exceeds RATIO-1.

Test Plan:
- Upsizing=1, m_tready=1, send beats 0x11,0x22,0x33,0x44 with tlast on 0x44 → one word m_tdata=0x44332211, m_tkeep=0xF, m_tlast=1, m_tvalid 1 cycle after the 4th beat.
- Upsizing=1, send 0xAA,0xBB,0xCC with tlast on 0xCC → m_tdata=0x00CCBBAA, m_tkeep=0x7, m_tlast=1; a single-beat packet 0x5A/tlast → 0x0000005A, keep=0x1.
- Upsizing=0, send 0x01,0x02(tlast) → two words 0x00000001 keep=0x1 last=0, then 0x00000002 keep=0x1 last=1.
- Backpressure: hold m_tready=0 after the first word of an 8-beat packet → s_tready=0 from the next cycle, m_tdata stable. Release → second word 0x88776655 with last=1, no beat lost or duplicated.
- Continuous stream, m_tready=1, 16 beats 0x00..0x0F with tlast on the last beat → 4 words back-to-back every 4 cycles, s_tready never drops, the final word 0x0F0E0D0C has last=1.
- Assert rst after 2 beats of a word, then send 0x10..0x13(tlast) → outputs 0 during reset, first word after reset 0x13121110 keep=0xF; toggling upsizing at cnt=2 has no effect on the current word.
